// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - round-robin arbiter sharing one registered-read memory slave among NREQ requesters
module membus_arbiter #(
    parameter  int LEN  = 256,
    parameter  int DW   = 8,
    parameter  int NREQ = 4,
    localparam int AW   = $clog2(LEN),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [AW-1:0]   req_addr [NREQ],
    input  logic [DW-1:0]   req_d    [NREQ],
    input  logic [NREQ-1:0] req_wr,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_d,
    output logic            m_wr,
    input  logic [DW-1:0]   m_q
);

    logic [IW-1:0] last_q, last_d;
    logic          rd_pend_q, rd_pend_d;
    logic [IW-1:0] rd_id_q, rd_id_d;
    logic          found;
    logic [IW-1:0] win;

    // Wraps at NREQ rather than 2^IW so unused index codes are never visited.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[IW-1:0];
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && rst && req[rr_index(last_q, k)]) begin
                found = 1'b1;
                win   = rr_index(last_q, k);
            end
        end
    end

    always_comb begin
        gnt       = '0;
        m_addr    = '0;
        m_d       = '0;
        m_wr      = 1'b0;
        last_d    = last_q;
        rd_id_d   = rd_id_q;
        rd_pend_d = 1'b0;
        if (found) begin
            gnt[win]  = 1'b1;
            m_addr    = req_addr[win];
            m_d       = req_d[win];
            m_wr      = req_wr[win];
            last_d    = win;
            rd_id_d   = win;
            rd_pend_d = ~req_wr[win];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= IW'(NREQ - 1);
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Read return is driven from registers and m_q only, never from req.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = rd_pend_q && (rd_id_q == IW'(i));
        end
        rdata = rd_pend_q ? m_q : '0;
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - randomized and directed bench for membus_arbiter against a behavioural model
module tb_membus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] req_addr [4];
    logic [7:0] req_d    [4];
    logic [3:0] req_wr;
    logic [3:0] gnt;
    logic [3:0] rvalid;
    logic [7:0] rdata;
    logic [7:0] m_addr;
    logic [7:0] m_d;
    logic       m_wr;
    logic [7:0] m_q;

    logic [2:0] req3;
    logic [7:0] req_addr3 [3];
    logic [7:0] req_d3    [3];
    logic [2:0] req_wr3;
    logic [2:0] gnt3;
    logic [2:0] rvalid3;
    logic [7:0] rdata3;
    logic [7:0] m_addr3;
    logic [7:0] m_d3;
    logic       m_wr3;
    logic [7:0] m_q3;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int         total = 0;
    int         bad   = 0;
    int         m_last;
    logic       exp_pend;
    int         exp_id;
    logic [7:0] exp_data;
    int         waited [4];

    membus_arbiter #(.LEN(256), .DW(8), .NREQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_d(req_d),
        .req_wr(req_wr), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .m_addr(m_addr), .m_d(m_d), .m_wr(m_wr), .m_q(m_q)
    );

    membus_arbiter #(.LEN(256), .DW(8), .NREQ(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_addr(req_addr3), .req_d(req_d3),
        .req_wr(req_wr3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
        .m_addr(m_addr3), .m_d(m_d3), .m_wr(m_wr3), .m_q(m_q3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        m_q <= mem[m_addr];
        if (m_wr) mem[m_addr] = m_d;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs already applied; checks the grant path, advances the model, then checks read return.
    task automatic step(output int w, output logic [3:0] g);
        int idx;
        #1;
        w = -1;
        if (rst) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (w < 0 && req[idx]) w = idx;
            end
        end
        g = gnt;
        if (w >= 0) begin
            chk("gnt", gnt, 32'd1 << w);
            chk("m_addr", m_addr, req_addr[w]);
            chk("m_d", m_d, req_d[w]);
            chk("m_wr", m_wr, req_wr[w]);
            m_last   = w;
            exp_pend = !req_wr[w];
            exp_id   = w;
            if (req_wr[w]) ref_mem[req_addr[w]] = req_d[w];
            else           exp_data = ref_mem[req_addr[w]];
        end else begin
            chk("gnt_idle", gnt, 0);
            chk("m_addr_idle", m_addr, 0);
            chk("m_d_idle", m_d, 0);
            chk("m_wr_idle", m_wr, 0);
            exp_pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rvalid", rvalid, exp_pend ? (32'd1 << exp_id) : 0);
        chk("rdata", rdata, exp_pend ? exp_data : 0);
    endtask

    task automatic do_reset();
        req = 4'hF;
        rst = 1'b0;
        #1;
        m_last   = 3;
        exp_pend = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_d", m_d, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        req = 4'h0;
        rst = 1'b1;
    endtask

    initial begin
        int         w;
        int         cyc;
        logic [3:0] g;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 8'(i);
            req_d[i]    = 8'(8'h10 + i);
            waited[i]   = 0;
        end
        req_wr = 4'h0;
        req3   = 3'b000;
        req_wr3 = 3'b000;
        m_q3   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            req_addr3[i] = 8'(i);
            req_d3[i]    = 8'h00;
        end
        exp_data = 8'h00;
        exp_id   = 0;

        do_reset();

        // NREQ = 3: after reset last = 2, so 0 and 2 alternate
        req3 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wrap3_gnt", gnt3, (k % 2 == 0) ? 3'b001 : 3'b100);
            @(negedge clk);
        end
        req3 = 3'b000;

        // Single reader: write 0x5A to 3, then read it back
        req = 4'b0001; req_wr = 4'b0001; req_addr[0] = 8'd3; req_d[0] = 8'h5A;
        step(w, g);
        chk("sr_gnt_wr", g, 4'b0001);
        chk("sr_no_rvalid_after_wr", rvalid, 0);
        req_wr = 4'b0000;
        step(w, g);
        chk("sr_gnt_rd", g, 4'b0001);
        chk("sr_rvalid", rvalid, 4'b0001);
        chk("sr_rdata", rdata, 8'h5A);
        req = 4'b0000;
        step(w, g);

        // Contention: four reads from 10..13 right after reset
        do_reset();
        req = 4'hF; req_wr = 4'h0;
        for (int i = 0; i < 4; i++) req_addr[i] = 8'(10 + i);
        for (int k = 0; k < 4; k++) begin
            step(w, g);
            chk("cont_gnt", g, 4'b0001 << k);
            chk("cont_rvalid", rvalid, 4'b0001 << k);
            chk("cont_rdata", rdata, 8'((10 + k) * 7 + 3));
            req[w] = 1'b0;
        end
        step(w, g);

        // Rotation: after last = 2, requesters 0 and 3 -> 3 then 0
        req = 4'b0100;
        step(w, g);
        req = 4'b1001;
        step(w, g);
        chk("rot_first", g, 4'b1000);
        req[3] = 1'b0;
        step(w, g);
        chk("rot_second", g, 4'b0001);
        req = 4'b0000;

        // Starvation: last = 1, everyone requests, requester 1 waits at most 4 cycles
        req = 4'b0010;
        step(w, g);
        req = 4'hF;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            step(w, g);
            cyc++;
            if (g[1]) break;
        end
        chk("starve_cyc", cyc, 4);
        req = 4'b0000;
        step(w, g);

        // Reset while a read return is outstanding
        req = 4'b0100; req_wr = 4'b0000;
        step(w, g);
        chk("mid_rvalid_before", rvalid, 4'b0100);
        do_reset();
        req = 4'hF;
        step(w, g);
        chk("post_rst_prio", g, 4'b0001);
        req = 4'h0;
        step(w, g);

        // Randomized traffic with a small address window to hit read-after-write cases
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]      = 1'b1;
                    req_addr[i] = 8'($urandom_range(0, 15));
                    req_d[i]    = 8'($urandom);
                    req_wr[i]   = 1'($urandom_range(0, 1));
                    waited[i]   = 0;
                end
            end
            step(w, g);
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !g[i]) waited[i]++;
            end
            if (w >= 0) begin
                chk("fair_wait", waited[w] < 4, 1'b1);
                waited[w] = 0;
                if ($urandom_range(0, 3) == 0) begin
                    req_addr[w] = 8'($urandom_range(0, 15));
                    req_d[w]    = 8'($urandom);
                    req_wr[w]   = 1'($urandom_range(0, 1));
                end else begin
                    req[w] = 1'b0;
                end
            end
        end
        req = 4'h0;
        step(w, g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
